// File: rtl/multdiv_sequencer.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) engine writing HI/LO; define MULTDIV_EARLY_TERM_EN for MULT early exit.
// Latency: MULT 32 cycles (fewer with early exit), DIV 33, DIV-by-zero 1; start is ignored while busy, with no queueing.
module multdiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DZ, S_DONE} state_t;

  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;     // MULT: Booth accumulator (one guard bit); DIV: partial remainder
  logic [WIDTH-1:0] q;       // MULT: multiplier/product low; DIV: dividend/quotient
  logic             q_1;
  logic [WIDTH-1:0] mcand;   // MULT: multiplicand; DIV: |divisor|
  logic             sign_a, sign_b;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mc_ext, booth_sum, acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic             q1_sh;
  logic             last_iter, mult_fin;
  logic [WIDTH:0]   div_sh, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, quot_nx, quot_fix, rem_fix;

  assign a_abs     = a[WIDTH-1] ? -a : a;
  assign b_abs     = b[WIDTH-1] ? -b : b;
  assign mc_ext    = {mcand[WIDTH-1], mcand};
  assign last_iter = (cnt == CNT_W'(WIDTH-1));

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_1})
      2'b10:   booth_sum = acc - mc_ext;
      2'b01:   booth_sum = acc + mc_ext;
      default: booth_sum = acc;
    endcase
  end

  assign acc_sh = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign q_sh   = {booth_sum[0], q[WIDTH-1:1]};
  assign q1_sh  = q[0];

`ifdef MULTDIV_EARLY_TERM_EN
  logic [WIDTH-1:0]   rem_mask;
  logic [CNT_W-1:0]   shamt;
  logic [2*WIDTH-1:0] prod_shift;
  assign rem_mask   = {WIDTH{1'b1}} >> (cnt + CNT_W'(1));
  assign shamt      = CNT_W'(WIDTH-1) - cnt;
  // acc_sh[WIDTH] always equals acc_sh[WIDTH-1], so the narrower sign is exact
  assign prod_shift = $signed({acc_sh[WIDTH-1:0], q_sh}) >>> shamt;
  assign mult_fin   = last_iter || (((q_sh & rem_mask) == '0) && !q1_sh);
`else
  assign mult_fin   = last_iter;
`endif

  assign div_sh     = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign div_trial  = div_sh - {1'b0, mcand};
  assign div_ge     = !div_trial[WIDTH];
  assign div_rem_nx = div_ge ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign quot_nx    = {q[WIDTH-2:0], div_ge};
  assign quot_fix   = (sign_a ^ sign_b) ? -q : q;
  assign rem_fix    = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start && op == OP_MULT)     state_nx = S_MULT;
        else if (start && op == OP_DIV) state_nx = (b == '0) ? S_DZ : S_DIV;
      end
      S_MULT:  if (mult_fin)  state_nx = S_DONE;
      S_DIV:   if (last_iter) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DZ:    state_nx = S_IDLE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      q      <= '0;
      q_1    <= 1'b0;
      mcand  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          // operands reloaded every idle cycle; only the accept edge matters
          cnt    <= '0;
          acc    <= '0;
          q_1    <= 1'b0;
          q      <= (op == OP_DIV) ? a_abs : b;
          mcand  <= (op == OP_DIV) ? b_abs : a;
          sign_a <= a[WIDTH-1];
          sign_b <= b[WIDTH-1];
        end
        S_MULT: begin
          acc <= acc_sh;
          q   <= q_sh;
          q_1 <= q1_sh;
          cnt <= cnt + CNT_W'(1);
          if (mult_fin) begin
`ifdef MULTDIV_EARLY_TERM_EN
            {hi, lo} <= prod_shift;
`else
            {hi, lo} <= {acc_sh[WIDTH-1:0], q_sh};
`endif
          end
        end
        S_DIV: begin
          acc <= {1'b0, div_rem_nx};
          q   <= quot_nx;
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          hi <= rem_fix;
          lo <= quot_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE) || (state == S_DZ);
  assign hilo_we  = (state == S_DONE);
  assign div_zero = (state == S_DZ);

endmodule
